ref_mem_loader: RTL and testbench



---
 rtl/ref_mem_pkg.sv | 26 ++
 rtl/ref_addr_gen.sv | 58 +++++
 rtl/ref_mem_loader.sv | 126 ++++++++++++
 tb/tb_ref_mem_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ref_mem_pkg.sv
// Shared constants, FSM state type and bank-select helper for the reference-memory loader.
package ref_mem_pkg;

  localparam int PIXEL    = 8;
  localparam int X        = 32;
  localparam int NUM_BANK = 32;
  localparam int ADDR_W   = 7;
  localparam int ROWS     = 96;
  localparam int CHUNKS   = 3;

  localparam int DATA_W  = X * PIXEL;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int CHUNK_W = $clog2(CHUNKS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ldr_state_t;

  // Row r lands in bank r % NUM_BANK so consecutive rows are readable in parallel.
  function automatic logic [NUM_BANK-1:0] onehot_bank(input logic [ROW_W-1:0] row);
    onehot_bank = NUM_BANK'(1) << (32'(row) % NUM_BANK);
  endfunction

endpackage

// File: rtl/ref_addr_gen.sv
// Row/chunk raster counters, per-load base latch and bank word-address generation.
module ref_addr_gen
  import ref_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base,
  input  logic              advance,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] word_addr,
  output logic              last
);

  logic [ROW_W-1:0]   row_q,   row_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [ADDR_W-1:0]  base_q,  base_d;
  logic [31:0]        addr_sum;

  always_comb begin
    row_d   = row_q;
    chunk_d = chunk_q;
    base_d  = base_q;
    if (clear) begin
      row_d   = '0;
      chunk_d = '0;
      base_d  = base;
    end else if (advance) begin
      if (chunk_q == CHUNK_W'(CHUNKS - 1)) begin
        chunk_d = '0;
        row_d   = row_q + ROW_W'(1);
      end else begin
        chunk_d = chunk_q + CHUNK_W'(1);
      end
    end
  end

  // Each group of NUM_BANK rows occupies CHUNKS consecutive words in every bank.
  always_comb begin
    addr_sum  = 32'(base_q) + (32'(row_q) / NUM_BANK) * CHUNKS + 32'(chunk_q);
    word_addr = addr_sum[ADDR_W-1:0];
    last      = (row_q == ROW_W'(ROWS - 1)) && (chunk_q == CHUNK_W'(CHUNKS - 1));
    row       = row_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      chunk_q <= '0;
      base_q  <= '0;
    end else begin
      row_q   <= row_d;
      chunk_q <= chunk_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: rtl/ref_mem_loader.sv
// Streams a raster search window into the banked reference memory write port.
// Optional stall counter output enabled by defining REF_LOADER_PERF_EN.
module ref_mem_loader
  import ref_mem_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          ref_input,
  output logic [NUM_BANK-1:0]        Bank_sel,
  output logic [NUM_BANK*ADDR_W-1:0] write_address_all,
  output logic                       busy,
  output logic                       done
`ifdef REF_LOADER_PERF_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  ldr_state_t state_q, state_d;

  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_BANK-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic              load_start;
  logic              accept;
  logic [ROW_W-1:0]  cur_row;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_last;

  ref_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .base      (base_addr),
    .advance   (accept),
    .row       (cur_row),
    .word_addr (cur_addr),
    .last      (cur_last)
  );

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    accept     = 1'b0;
    load_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && cur_last) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port is registered one cycle behind the accept; data/address hold when idle.
  always_comb begin
    data_d = data_q;
    bank_d = '0;
    addr_d = addr_q;
    if (accept) begin
      data_d = in_data;
      bank_d = onehot_bank(cur_row);
      addr_d = cur_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
    end
  end

  assign ref_input         = data_q;
  assign Bank_sel          = bank_q;
  assign write_address_all = {NUM_BANK{addr_q}};
  assign busy              = (state_q == LOAD);
  assign done              = (state_q == DONE);

`ifdef REF_LOADER_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (load_start) begin
      stall_d = '0;
    end else if ((state_q == LOAD) && !in_valid && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ref_mem_loader.sv
// Directed self-checking bench for ref_mem_loader (optionally with REF_LOADER_PERF_EN).
module tb_ref_mem_loader;

  localparam int NB    = 32;
  localparam int AW    = 7;
  localparam int DW    = 256;
  localparam int BEATS = 288;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [DW-1:0]  ref_input;
  logic [NB-1:0]  Bank_sel;
  logic [NB*AW-1:0] write_address_all;
  logic           busy;
  logic           done;
`ifdef REF_LOADER_PERF_EN
  logic [15:0]    stall_cnt;
`endif

  int vectors = 0;
  int misc    = 0;

  logic [NB-1:0] cap_bank [BEATS];
  logic [AW-1:0] cap_addr [BEATS];
  int            nwrites;

  ref_mem_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .ref_input         (ref_input),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .busy              (busy),
    .done              (done)
`ifdef REF_LOADER_PERF_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen(input int k, input int salt);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = 32'(k) * 32'h9E37_79B1 + 32'(i * 7 + salt + 1);
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
    int row, chunk, a;
    row   = k / 3;
    chunk = k % 3;
    a     = int'(base) + (row / 32) * 3 + chunk;
    return AW'(a % 128);
  endfunction

  function automatic logic [NB-1:0] exp_bank(input int k);
    logic [NB-1:0] b;
    b = '0;
    b[(k / 3) % 32] = 1'b1;
    return b;
  endfunction

  task automatic run_load(input logic [AW-1:0] base, input bit toggle, input int abort_at,
                          input bit poke_start, input bit poke_done);
    int k, cyc, low;
    bit pend;
    logic [DW-1:0] last_d;
    logic [AW-1:0] last_a;
    k = 0; cyc = 0; low = 0;
    last_d = '0; last_a = '0;
    start = 1'b1; base_addr = base; in_valid = 1'b0;
    step();
    start = 1'b0;
    base_addr = 7'h55;
    chk("ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
    chk("no_write_at_start", Bank_sel, 0);
    while (1) begin
      if (cyc >= 2000) begin
        vectors++;
        misc++;
        $error("FAIL timeout: observed %0d writes expected %0d", k, BEATS);
        break;
      end
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      if (!in_valid) low++;
      in_data = in_valid ? gen(k, int'(base)) : {8{32'hDEAD_BEEF}};
      start = poke_start && (k == 100);
      pend = in_valid;
      step();
      cyc++;
      start = 1'b0;
      if (pend) begin
        cap_bank[k] = Bank_sel;
        cap_addr[k] = write_address_all[0 +: AW];
        chk("bank_sel", Bank_sel, exp_bank(k));
        chk("bank_onehot", $countones(Bank_sel), 1);
        chk("addr_lane0", write_address_all[0 +: AW], exp_addr(base, k));
        chk("addr_lane31", write_address_all[31*AW +: AW], exp_addr(base, k));
        chk("ref_input", ref_input, gen(k, int'(base)));
        last_d = gen(k, int'(base));
        last_a = exp_addr(base, k);
        k++;
      end else begin
        chk("idle_bank_zero", Bank_sel, 0);
        chk("idle_data_hold", ref_input, last_d);
        chk("idle_addr_hold", write_address_all[17*AW +: AW], last_a);
      end
      if (abort_at >= 0 && k == abort_at) begin
        rst = 1'b1; in_valid = 1'b1; in_data = gen(k, int'(base));
        step();
        rst = 1'b0;
        chk("abort_bank_zero", Bank_sel, 0);
        chk("abort_ready_low", in_ready, 0);
        chk("abort_no_done", done, 0);
        chk("abort_busy_low", busy, 0);
        step();
        chk("abort_still_no_write", Bank_sel, 0);
        chk("abort_still_idle", in_ready, 0);
        chk("abort_still_no_done", done, 0);
        in_valid = 1'b0;
        nwrites = k;
        return;
      end
      if (k == BEATS) begin
        chk("done_with_last_write", done, 1);
        chk("busy_low_in_done", busy, 0);
        chk("ready_low_in_done", in_ready, 0);
        break;
      end
      chk("done_low_in_load", done, 0);
      chk("ready_in_load", in_ready, 1);
    end
    in_valid = 1'b0;
    start = poke_done;
    step();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_ready_low", in_ready, 0);
    chk("idle_busy_low", busy, 0);
    chk("idle_bank_zero_after", Bank_sel, 0);
    step();
    chk("start_in_done_ignored", in_ready, 0);
`ifdef REF_LOADER_PERF_EN
    chk("stall_cnt", stall_cnt, low);
`endif
    nwrites = k;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bank_sel", Bank_sel, 0);
    chk("rst_ref_input", ref_input, 0);
    chk("rst_waddr", write_address_all, 0);
`ifdef REF_LOADER_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    step();
    chk("idle_no_ready", in_ready, 0);

    run_load(7'h00, 1'b0, -1, 1'b0, 1'b0);
    chk("base0_writes", nwrites, 288);
    chk("b0_beat0_bank", cap_bank[0], 32'h1);
    chk("b0_beat0_addr", cap_addr[0], 7'h00);
    chk("b0_beat3_bank", cap_bank[3], 32'h2);
    chk("b0_beat3_addr", cap_addr[3], 7'h00);
    chk("b0_beat96_bank", cap_bank[96], 32'h1);
    chk("b0_beat96_addr", cap_addr[96], 7'h03);
    chk("b0_beat287_bank", cap_bank[287], 32'h8000_0000);
    chk("b0_beat287_addr", cap_addr[287], 7'h08);

    run_load(7'h40, 1'b0, -1, 1'b0, 1'b0);
    chk("b40_writes", nwrites, 288);
    chk("b40_beat0_addr", cap_addr[0], 7'h40);
    chk("b40_beat287_addr", cap_addr[287], 7'h48);

    run_load(7'h7C, 1'b0, -1, 1'b0, 1'b0);
    chk("b7c_beat0_addr", cap_addr[0], 7'h7C);
    chk("b7c_beat98_addr", cap_addr[98], 7'h01);
    chk("b7c_beat287_addr", cap_addr[287], 7'h04);

    run_load(7'h10, 1'b1, -1, 1'b0, 1'b1);
    chk("toggle_writes", nwrites, 288);
    chk("toggle_beat287_addr", cap_addr[287], 7'h18);

    run_load(7'h00, 1'b0, 51, 1'b0, 1'b0);
    chk("abort_writes", nwrites, 51);

    run_load(7'h20, 1'b0, -1, 1'b1, 1'b0);
    chk("restart_poke_writes", nwrites, 288);
    chk("restart_beat287_bank", cap_bank[287], 32'h8000_0000);
    chk("restart_beat287_addr", cap_addr[287], 7'h28);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
